// File: rtl/sprite_motion.sv
// Bouncing-box motion engine: advances one sprite every FRAME_DIV vsync falls,
// reflecting off the visible-area edges; position changes only just after vsync.
module sprite_motion #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       vsync,
  input  logic       enable,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       frame_tick,
  output logic       bounce,
  output logic       corner_hit
);

  localparam logic [9:0]  XMAX     = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]  YMAX     = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] STEP_X_W = 11'(STEP_X);
  localparam logic [10:0] STEP_Y_W = 11'(STEP_Y);
  localparam logic [7:0]  CNT_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0]  X_RST    = 10'(X0);
  localparam logic [9:0]  Y_RST    = 10'(Y0);

  typedef enum logic [1:0] {S_WAIT, S_MOVE_X, S_MOVE_Y} state_t;

  state_t      state, state_nx;
  logic        vsync_q;
  logic        fall;
  logic [7:0]  frame_cnt;
  logic        rev_x_p1;
  logic [10:0] x_step, y_step;

  // One axis update in 11-bit arithmetic: returns {reversed, new_position}.
  // Landing exactly on a limit keeps direction; overshooting clamps and reverses.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic fwd,
                                            input logic [10:0] step, input logic [9:0] lim);
    logic [10:0] pos_w;
    logic [10:0] sum;
    logic [10:0] diff;
    pos_w = {1'b0, pos};
    sum   = pos_w + step;
    diff  = pos_w - step;
    if (fwd)
      axis_step = (sum > {1'b0, lim}) ? {1'b1, lim} : {1'b0, sum[9:0]};
    else
      axis_step = (pos_w < step) ? {1'b1, 10'd0} : {1'b0, diff[9:0]};
  endfunction

  assign fall   = vsync_q & ~vsync;
  assign x_step = axis_step(sprite_x, dir_x, STEP_X_W, XMAX);
  assign y_step = axis_step(sprite_y, dir_y, STEP_Y_W, YMAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_WAIT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:   if (fall && enable && frame_cnt == CNT_LAST) state_nx = S_MOVE_X;
      S_MOVE_X: state_nx = S_MOVE_Y;
      S_MOVE_Y: state_nx = S_WAIT;
      default:  state_nx = S_WAIT;
    endcase
  end

  // Stage boundary: x settles after MOVE_X, y and the bounce flags after MOVE_Y.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      bounce     <= 1'b0;
      corner_hit <= 1'b0;
      frame_cnt  <= 8'd0;
      sprite_x   <= X_RST;
      sprite_y   <= Y_RST;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      rev_x_p1   <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= fall;
      bounce     <= 1'b0;
      corner_hit <= 1'b0;
      if (state == S_WAIT && fall && enable)
        frame_cnt <= (frame_cnt == CNT_LAST) ? 8'd0 : frame_cnt + 8'd1;
      if (state == S_MOVE_X) begin
        sprite_x <= x_step[9:0];
        dir_x    <= dir_x ^ x_step[10];
        rev_x_p1 <= x_step[10];
      end
      if (state == S_MOVE_Y) begin
        sprite_y   <= y_step[9:0];
        dir_y      <= dir_y ^ y_step[10];
        bounce     <= rev_x_p1 | y_step[10];
        corner_hit <= rev_x_p1 & y_step[10];
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Scoreboard bench for sprite_motion: randomized vsync/enable traffic, expected
// ticks and updates queued by a plain-integer bouncing-box model.
module tb_sprite_motion;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SPRITE_W  = 32;
  localparam int SPRITE_H  = 32;
  localparam int STEP_X    = 2;
  localparam int STEP_Y    = 1;
  localparam int FRAME_DIV = 2;
  localparam int X0        = 600;
  localparam int Y0        = 444;
  localparam int XMAX      = H_ACTIVE - SPRITE_W;
  localparam int YMAX      = V_ACTIVE - SPRITE_H;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       vsync = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] sprite_x, sprite_y;
  logic       dir_x, dir_y, frame_tick, bounce, corner_hit;

  sprite_motion #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
    .STEP_X(STEP_X), .STEP_Y(STEP_Y), .FRAME_DIV(FRAME_DIV), .X0(X0), .Y0(Y0)
  ) dut (
    .clk(clk), .resetn(resetn), .vsync(vsync), .enable(enable),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .dir_x(dir_x), .dir_y(dir_y),
    .frame_tick(frame_tick), .bounce(bounce), .corner_hit(corner_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due; int x; int y; int dx; int dy; int b; int c;
  } upd_t;

  int   tick_q[$];
  upd_t upd_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state of the bouncing box
  int   m_x, m_y, m_dx, m_dy, m_cnt, last_acc;
  logic vs_prev;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1; m_cnt = 0;
    last_acc = -100; vs_prev = 1'b1;
    tick_q.delete(); upd_q.delete();
  endtask

  // Move along one axis; returns 1 if the direction flipped.
  function automatic int move_axis(inout int pos, inout int dir, input int step, input int lim);
    int target;
    target = dir ? pos + step : pos - step;
    if (target > lim) begin pos = lim; dir = 0; return 1; end
    if (target < 0)   begin pos = 0;   dir = 1; return 1; end
    pos = target;
    return 0;
  endfunction

  // Drive one cycle of inputs and predict what it causes.
  task automatic step(input logic v, input logic e);
    upd_t u;
    int   rx, ry;
    vsync = v; enable = e;
    if (vs_prev && !v) begin
      tick_q.push_back(cyc + 1);
      if (e && cyc >= last_acc + 3) begin
        if (m_cnt == FRAME_DIV - 1) begin
          m_cnt = 0;
          last_acc = cyc;
          rx = move_axis(m_x, m_dx, STEP_X, XMAX);
          ry = move_axis(m_y, m_dy, STEP_Y, YMAX);
          u.due = cyc + 3; u.x = m_x; u.y = m_y; u.dx = m_dx; u.dy = m_dy;
          u.b = (rx | ry); u.c = (rx & ry);
          upd_q.push_back(u);
        end else begin
          m_cnt++;
        end
      end
    end
    vs_prev = v;
    @(posedge clk); #1;
  endtask

  task automatic frame(input int hi, input int lo, input logic e);
    for (int i = 0; i < hi; i++) step(1'b1, e);
    for (int i = 0; i < lo; i++) step(1'b0, e);
  endtask

  task automatic check_reset_values();
    chk("rst_x", int'(sprite_x), X0);
    chk("rst_y", int'(sprite_y), Y0);
    chk("rst_dir_x", int'(dir_x), 1);
    chk("rst_dir_y", int'(dir_y), 1);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_corner", int'(corner_hit), 0);
  endtask

  // Monitor: pops expectations when the DUT presents ticks or completed updates.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_tick) begin
        if (tick_q.size() == 0) chk("tick_unexpected", 1, 0);
        else chk("tick_cycle", cyc, tick_q.pop_front());
      end else if (tick_q.size() != 0 && tick_q[0] <= cyc) begin
        chk("tick_missing", cyc, tick_q.pop_front());
      end
      if (upd_q.size() != 0 && upd_q[0].due == cyc) begin
        upd_t e;
        e = upd_q.pop_front();
        chk("upd_x", int'(sprite_x), e.x);
        chk("upd_y", int'(sprite_y), e.y);
        chk("upd_dir_x", int'(dir_x), e.dx);
        chk("upd_dir_y", int'(dir_y), e.dy);
        chk("upd_bounce", int'(bounce), e.b);
        chk("upd_corner", int'(corner_hit), e.c);
      end else begin
        if (bounce) chk("bounce_idle", 1, 0);
        if (corner_hit) chk("corner_idle", 1, 0);
      end
    end
  end

  initial begin
    logic en;
    int   acc;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    resetn = 1'b1;
    step(1'b1, 1'b1);

    // Clean frames: x climbs 602..608 and both axes reverse together on update 5
    for (int f = 0; f < 14; f++) frame(4, 2, 1'b1);

    // Randomized vsync spacing (including falls during an update) and enable
    en = 1'b1;
    for (int f = 0; f < 350; f++) begin
      if ($urandom_range(0, 3) == 0) en = ~en;
      frame($urandom_range(1, 6), 0, en);
      for (int i = $urandom_range(1, 5); i > 0; i--)
        step(1'b0, ($urandom_range(0, 7) == 0) ? ~en : en);
    end

    // Long vsync low: a single edge
    frame(4, 800, 1'b1);
    frame(4, 2, 1'b1);

    // Start an update and reset during MOVE_Y
    acc = 0;
    for (int t = 0; t < FRAME_DIV + 1 && acc == 0; t++) begin
      frame(4, 0, 1'b1);
      step(1'b0, 1'b1);
      if (last_acc == cyc - 1) acc = 1;
    end
    chk("reset_test_update_started", acc, 1);
    step(1'b0, 1'b1);
    resetn = 1'b0;
    vsync = 1'b1;
    model_reset();
    #2;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 1'b1);

    for (int f = 0; f < 60; f++) frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 4) != 0);

    frame(8, 0, 1'b1);
    chk("tick_q_drained", tick_q.size(), 0);
    chk("upd_q_drained", upd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
